// File: rtl/servo_pwm_decoder.sv
// Servo PWM pulse-width decoder: measures the high time of a synchronised PWM
// line, classifies it as centre / -90 / +90, and flags bad pulses and signal loss.
module servo_pwm_decoder #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned TOL_US      = 100,
  parameter int unsigned TIMEOUT_US  = 25000
) (
  input  logic        d_in_clk,
  input  logic        d_reset,
  input  logic        d_enable,
  input  logic        d_pwm_in,
  output logic [7:0]  d_position,
  output logic [31:0] d_pulse_ticks,
  output logic        d_valid,
  output logic        d_error,
  output logic        d_signal_lost
);

  localparam logic [31:0] CPM   = 32'(CLK_FREQ_HZ / 1000000);
  localparam logic [31:0] W_M90 = 32'd500 * CPM;
  localparam logic [31:0] W_CTR = 32'd1500 * CPM;
  localparam logic [31:0] W_P90 = 32'd2500 * CPM;
  localparam logic [31:0] W_TOL = 32'(TOL_US) * CPM;
  localparam logic [31:0] W_MAX = 32'd3000 * CPM;
  localparam logic [31:0] T_OUT = 32'(TIMEOUT_US) * CPM;

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH, LOW} state_t;

  function automatic logic [31:0] absDiff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        s_d_q, rise_q, fall_q;
  logic [2:0]  prime_q;
  logic [31:0] width_q, width_d, gap_q, gap_d, ticks_q, ticks_d;
  logic [7:0]  pos_q, pos_d;
  logic        valid_q, valid_d, error_q, error_d, lost_q, lost_d;
  logic        rise, fall, timeout;

  assign rise    = sync_q[1] & ~s_d_q;
  assign fall    = ~sync_q[1] & s_d_q;
  assign timeout = (gap_q == T_OUT);

  // Edge strobes are registered so they line up with s_d_q, which serves as
  // the pulse level; prime_q keeps WAIT_LOW from trusting the reset-cleared flops.
  always_ff @(posedge d_in_clk or negedge d_reset) begin
    if (!d_reset) begin
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      prime_q <= '0;
      state_q <= WAIT_LOW;
      width_q <= '0;
      gap_q   <= '0;
      ticks_q <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], d_pwm_in};
      s_d_q   <= sync_q[1];
      rise_q  <= rise;
      fall_q  <= fall;
      prime_q <= {prime_q[1:0], 1'b1};
      state_q <= state_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      ticks_q <= ticks_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      error_q <= error_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    gap_d   = rise_q ? 32'd0 : (timeout ? gap_q : gap_q + 32'd1);
    ticks_d = ticks_q;
    pos_d   = pos_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    lost_d  = rise_q ? 1'b0 : (timeout ? 1'b1 : lost_q);

    unique case (state_q)
      WAIT_LOW: begin
        if (prime_q[2] && !s_d_q) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise_q) begin
          state_d = HIGH;
          width_d = 32'd1;
        end
      end
      HIGH: begin
        if (fall_q) begin
          state_d = LOW;
          ticks_d = width_q;
          if (absDiff(width_q, W_CTR) <= W_TOL) begin
            pos_d   = 8'd0;
            valid_d = 1'b1;
          end else if (absDiff(width_q, W_M90) <= W_TOL) begin
            pos_d   = 8'd1;
            valid_d = 1'b1;
          end else if (absDiff(width_q, W_P90) <= W_TOL) begin
            pos_d   = 8'd2;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (width_q == W_MAX) begin
          state_d = WAIT_LOW;
          ticks_d = W_MAX;
          error_d = 1'b1;
        end else if (timeout) begin
          state_d = WAIT_LOW;
        end else if (s_d_q) begin
          width_d = width_q + 32'd1;
        end
      end
      LOW: begin
        if (rise_q) begin
          state_d = HIGH;
          width_d = 32'd1;
        end else if (timeout) begin
          state_d = WAIT_LOW;
        end
      end
      default: state_d = WAIT_LOW;
    endcase

    // Disabling parks the FSM but leaves the reported results untouched.
    if (!d_enable) begin
      state_d = WAIT_LOW;
      width_d = '0;
      gap_d   = '0;
      valid_d = 1'b0;
      error_d = 1'b0;
      pos_d   = pos_q;
      ticks_d = ticks_q;
      lost_d  = lost_q;
    end
  end

  assign d_position    = pos_q;
  assign d_pulse_ticks = ticks_q;
  assign d_valid       = valid_q;
  assign d_error       = error_q;
  assign d_signal_lost = lost_q;

endmodule
